// File: rtl/riscv_pkg.sv
// Shared types for the data-memory path.
//   mem_access_size_t : load/store access width carried on data_byte_i
//   mem_resp_state_t  : state of the data_mem_responder request FSM
package riscv_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        RESERVED  = 2'b10,
        WORD      = 2'b11
    } mem_access_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } mem_resp_state_t;

    // Byte-lane enables touched by a store of the given size at the given
    // byte offset within the word. RESERVED touches nothing.
    function automatic logic [3:0] store_lanes(input mem_access_size_t size,
                                               input logic [1:0]       byte_off);
        logic [3:0] be;
        be = '0;
        case (size)
            BYTE:      be = 4'b0001 << byte_off;
            HALF_WORD: be = byte_off[1] ? 4'b1100 : 4'b0011;
            WORD:      be = 4'b1111;
            default:   be = '0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the addressed byte/half/word out of
// a 32-bit memory word, moves it to bit 0 and sign- or zero-extends it.
//   word       : raw 32-bit word read from the array
//   byte_off   : address bits [1:0]
//   size       : access width
//   zero_extnd : 1 = zero-extend, 0 = sign-extend (ignored for WORD)
//   data       : aligned, extended result (0 for RESERVED)
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0]      word,
    input  logic [1:0]       byte_off,
    input  mem_access_size_t size,
    input  logic             zero_extnd,
    output logic [31:0]      data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word[8*byte_off +: 8];
        sel_half = byte_off[1] ? word[31:16] : word[15:0];
        data     = '0;
        case (size)
            BYTE:      data = zero_extnd ? {24'h0, sel_byte}
                                         : {{24{sel_byte[7]}}, sel_byte};
            HALF_WORD: data = zero_extnd ? {16'h0, sel_half}
                                         : {{16{sel_half[15]}}, sel_half};
            WORD:      data = word;
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory model with a three-state request FSM.
// A request is captured in IDLE, answered LATENCY cycles later with a
// one-cycle data_ack_o pulse, and the FSM then returns to IDLE.
//   clk, reset      : clock, asynchronous active-high reset
//   data_req_i      : request valid (sampled in IDLE only)
//   data_wr_i       : 1 = store, 0 = load
//   data_addr_i     : byte address
//   data_byte_i     : access size
//   zero_extnd_i    : load extension select
//   data_wdata_i    : store data, right-aligned
//   data_ack_o      : response pulse
//   data_rdata_o    : extended load data (0 for stores and faults)
//   data_err_o      : access fault flag
//   busy_o          : FSM not in IDLE
module data_mem_responder
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_req_i,
    input  logic             data_wr_i,
    input  logic [31:0]      data_addr_i,
    input  mem_access_size_t data_byte_i,
    input  logic             zero_extnd_i,
    input  logic [31:0]      data_wdata_i,
    output logic             data_ack_o,
    output logic [31:0]      data_rdata_o,
    output logic             data_err_o,
    output logic             busy_o
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    mem_resp_state_t  state;
    logic [3:0]       cnt;

    logic             cap_wr;
    logic [31:0]      cap_addr;
    mem_access_size_t cap_size;
    logic             cap_zx;
    logic [31:0]      cap_wdata;

    logic             src_wr;
    logic [31:0]      src_addr;
    mem_access_size_t src_size;
    logic             src_zx;
    logic [31:0]      src_wdata;

    logic             fault;
    logic             enter_resp;
    logic [IDX_W-1:0] idx;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic [31:0]      rd_word;
    logic [31:0]      load_data;

    logic [31:0]      mem [DEPTH_WORDS];

    // The access is performed on the edge entering RESP. With LATENCY=1
    // that is the acceptance edge itself, so the live inputs stand in for
    // the not-yet-loaded capture registers.
    always_comb begin
        if (state == IDLE) begin
            src_wr    = data_wr_i;
            src_addr  = data_addr_i;
            src_size  = data_byte_i;
            src_zx    = zero_extnd_i;
            src_wdata = data_wdata_i;
        end else begin
            src_wr    = cap_wr;
            src_addr  = cap_addr;
            src_size  = cap_size;
            src_zx    = cap_zx;
            src_wdata = cap_wdata;
        end
    end

    always_comb begin
        fault = 1'b0;
        case (src_size)
            RESERVED:  fault = 1'b1;
            HALF_WORD: fault = src_addr[0];
            WORD:      fault = |src_addr[1:0];
            default:   fault = 1'b0;
        endcase
        if ({2'b00, src_addr[31:2]} >= 32'(DEPTH_WORDS))
            fault = 1'b1;
    end

    // Gated by reset so a request held high during reset cannot write.
    assign enter_resp = !reset &&
                        (((state == IDLE) && data_req_i && (LATENCY == 1)) ||
                         ((state == WAIT) && (cnt == 4'd0)));

    assign idx     = src_addr[IDX_W+1:2];
    assign rd_word = mem[idx];

    always_comb begin
        wr_be   = store_lanes(src_size, src_addr[1:0]);
        wr_data = '0;
        case (src_size)
            BYTE:      wr_data = {4{src_wdata[7:0]}};
            HALF_WORD: wr_data = {2{src_wdata[15:0]}};
            WORD:      wr_data = src_wdata;
            default:   wr_data = '0;
        endcase
    end

    load_align u_load_align (
        .word       (rd_word),
        .byte_off   (src_addr[1:0]),
        .size       (src_size),
        .zero_extnd (src_zx),
        .data       (load_data)
    );

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (enter_resp && src_wr && !fault) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_be[i])
                    mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            cap_wr       <= 1'b0;
            cap_addr     <= '0;
            cap_size     <= BYTE;
            cap_zx       <= 1'b0;
            cap_wdata    <= '0;
            data_ack_o   <= 1'b0;
            data_err_o   <= 1'b0;
            data_rdata_o <= '0;
            busy_o       <= 1'b0;
        end else begin
            data_ack_o   <= 1'b0;
            data_err_o   <= 1'b0;
            data_rdata_o <= '0;
            case (state)
                IDLE: begin
                    if (data_req_i) begin
                        cap_wr    <= data_wr_i;
                        cap_addr  <= data_addr_i;
                        cap_size  <= data_byte_i;
                        cap_zx    <= zero_extnd_i;
                        cap_wdata <= data_wdata_i;
                        cnt       <= 4'(LATENCY - 1);
                        busy_o    <= 1'b1;
                        state     <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0)
                        state <= RESP;
                    else
                        cnt <= cnt - 4'd1;
                end
                RESP: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
            if (enter_resp) begin
                data_ack_o   <= 1'b1;
                data_err_o   <= fault;
                data_rdata_o <= (fault || src_wr) ? '0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    import riscv_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic             clk = 1'b0;
    logic             reset;
    logic             data_req_i;
    logic             data_wr_i;
    logic [31:0]      data_addr_i;
    mem_access_size_t data_byte_i;
    logic             zero_extnd_i;
    logic [31:0]      data_wdata_i;
    logic             data_ack_o;
    logic [31:0]      data_rdata_o;
    logic             data_err_o;
    logic             busy_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_req_i   (data_req_i),
        .data_wr_i    (data_wr_i),
        .data_addr_i  (data_addr_i),
        .data_byte_i  (data_byte_i),
        .zero_extnd_i (zero_extnd_i),
        .data_wdata_i (data_wdata_i),
        .data_ack_o   (data_ack_o),
        .data_rdata_o (data_rdata_o),
        .data_err_o   (data_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // One transaction from an idle DUT. lat = number of rising edges after
    // the acceptance edge before data_ack_o is seen (-1 on timeout).
    // Inputs are scrambled after acceptance to show they are captured.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                          input logic zx, input logic [31:0] wd,
                          output logic [31:0] rdo, output logic ero, output int lato);
        @(negedge clk);
        data_req_i   = 1'b1;
        data_wr_i    = wr;
        data_addr_i  = addr;
        data_byte_i  = mem_access_size_t'(sz);
        zero_extnd_i = zx;
        data_wdata_i = wd;
        @(posedge clk);
        #1;
        data_req_i   = 1'b0;
        data_wr_i    = ~wr;
        data_addr_i  = addr ^ 32'h4;
        zero_extnd_i = ~zx;
        data_wdata_i = ~wd;
        lato = -1;
        rdo  = 32'hx;
        ero  = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (data_ack_o) begin
                lato = c;
                rdo  = data_rdata_o;
                ero  = data_err_o;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        data_req_i = 1'b0; data_wr_i = 1'b0; data_addr_i = '0;
        data_byte_i = WORD; zero_extnd_i = 1'b0; data_wdata_i = '0;
        repeat (2) @(negedge clk);
        total++; if (data_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", data_ack_o); end
        total++; if (data_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", data_err_o); end
        total++; if (data_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", data_rdata_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        reset = 1'b0;
    endtask

    task automatic test_word;
        access(1'b1, 32'h10, 2'b11, 1'b0, 32'hDEADBEEF, rd, er, lat);
        total++; if (lat !== LAT) begin bad++; $display("FAIL word_st_lat got=%0d exp=%0d", lat, LAT); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL word_st_err got=%b exp=0", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL word_st_rdata got=%h exp=0", rd); end
        access(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, rd, er, lat);
        total++; if (lat !== LAT) begin bad++; $display("FAIL word_ld_lat got=%0d exp=%0d", lat, LAT); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_ld_rdata got=%h exp=deadbeef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL word_ld_err got=%b exp=0", er); end
        @(negedge clk);
        total++; if (data_ack_o !== 1'b0) begin bad++; $display("FAIL word_ack_pulse got=%b exp=0", data_ack_o); end
    endtask

    task automatic test_byte_lanes;
        access(1'b1, 32'h13, 2'b00, 1'b0, 32'hAAAAAA80, rd, er, lat);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL byte_st_err got=%b exp=0", er); end
        access(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL byte_ld_sext got=%h exp=ffffff80", rd); end
        access(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL byte_ld_zext got=%h exp=00000080", rd); end
        access(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h80ADBEEF) begin bad++; $display("FAIL byte_ld_word got=%h exp=80adbeef", rd); end
        access(1'b0, 32'h11, 2'b00, 1'b1, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h000000BE) begin bad++; $display("FAIL byte_ld_lane1 got=%h exp=000000be", rd); end
    endtask

    task automatic test_half;
        access(1'b1, 32'h20, 2'b11, 1'b0, 32'h11223344, rd, er, lat);
        access(1'b1, 32'h22, 2'b01, 1'b0, 32'h55558001, rd, er, lat);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL half_st_err got=%b exp=0", er); end
        access(1'b0, 32'h22, 2'b01, 1'b0, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hFFFF8001) begin bad++; $display("FAIL half_ld_sext got=%h exp=ffff8001", rd); end
        access(1'b0, 32'h22, 2'b01, 1'b1, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h00008001) begin bad++; $display("FAIL half_ld_zext got=%h exp=00008001", rd); end
        access(1'b0, 32'h20, 2'b11, 1'b0, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h80013344) begin bad++; $display("FAIL half_ld_word got=%h exp=80013344", rd); end
        access(1'b0, 32'h21, 2'b01, 1'b0, 32'h0, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL half_mis_err got=%b exp=1", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL half_mis_rdata got=%h exp=0", rd); end
    endtask

    task automatic test_faults;
        access(1'b1, 32'h14, 2'b11, 1'b0, 32'hCAFEF00D, rd, er, lat);
        access(1'b1, 32'h0,  2'b11, 1'b0, 32'h0BADC0DE, rd, er, lat);
        // misaligned word store
        access(1'b1, 32'h16, 2'b11, 1'b0, 32'h0, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL mis_word_err got=%b exp=1", er); end
        total++; if (lat !== LAT) begin bad++; $display("FAIL mis_word_lat got=%0d exp=%0d", lat, LAT); end
        access(1'b0, 32'h14, 2'b11, 1'b0, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL mis_word_nowr got=%h exp=cafef00d", rd); end
        // reserved size store
        access(1'b1, 32'h14, 2'b10, 1'b0, 32'h0, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL rsvd_err got=%b exp=1", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rsvd_rdata got=%h exp=0", rd); end
        access(1'b0, 32'h14, 2'b11, 1'b0, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL rsvd_nowr got=%h exp=cafef00d", rd); end
        // out-of-range store must not alias onto word 0
        access(1'b1, 32'h4*DEPTH, 2'b11, 1'b0, 32'h0, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL oor_st_err got=%b exp=1", er); end
        access(1'b0, 32'h4*DEPTH, 2'b11, 1'b0, 32'h0, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL oor_ld_err got=%b exp=1", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_ld_rdata got=%h exp=0", rd); end
        access(1'b0, 32'h0, 2'b11, 1'b0, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h0BADC0DE) begin bad++; $display("FAIL oor_nowr got=%h exp=0badc0de", rd); end
        // last legal word
        access(1'b1, 32'h4*DEPTH - 32'h4, 2'b11, 1'b0, 32'hA5A5_5A5A, rd, er, lat);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL last_st_err got=%b exp=0", er); end
        access(1'b0, 32'h4*DEPTH - 32'h4, 2'b11, 1'b0, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hA5A5_5A5A) begin bad++; $display("FAIL last_ld got=%h exp=a5a55a5a", rd); end
    endtask

    task automatic test_reset_midflight;
        int acks;
        access(1'b1, 32'h30, 2'b11, 1'b0, 32'h55AA55AA, rd, er, lat);
        @(negedge clk);
        data_req_i = 1'b1; data_wr_i = 1'b1; data_addr_i = 32'h30;
        data_byte_i = WORD; data_wdata_i = 32'h12345678;
        @(posedge clk);
        #1 data_req_i = 1'b0;
        @(negedge clk);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL mid_busy_wait got=%b exp=1", busy_o); end
        reset = 1'b1;
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_busy_rst got=%b exp=0", busy_o); end
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (data_ack_o) acks++;
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (data_ack_o) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL mid_no_ack got=%0d exp=0", acks); end
        access(1'b0, 32'h30, 2'b11, 1'b0, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h55AA55AA) begin bad++; $display("FAIL mid_nowr got=%h exp=55aa55aa", rd); end
    endtask

    // Request held high: accept, LAT edges to RESP, one edge back to IDLE,
    // one IDLE cycle before the next acceptance -> acks every LAT+2 edges,
    // first ack after edge 1+LAT.
    task automatic test_back_to_back;
        int  acks;
        logic exp_ack;
        @(negedge clk);
        data_req_i = 1'b1; data_wr_i = 1'b0; data_addr_i = 32'h30;
        data_byte_i = WORD; zero_extnd_i = 1'b0;
        acks = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_ack = ((k - 1 - LAT) >= 0) && (((k - 1 - LAT) % (LAT + 2)) == 0);
            total++; if (data_ack_o !== exp_ack) begin bad++; $display("FAIL b2b_ack k=%0d got=%b exp=%b", k, data_ack_o, exp_ack); end
            if (data_ack_o) begin
                acks++;
                total++; if (data_rdata_o !== 32'h55AA55AA) begin bad++; $display("FAIL b2b_rdata k=%0d got=%h exp=55aa55aa", k, data_rdata_o); end
            end
        end
        data_req_i = 1'b0;
        total++; if (acks !== 5) begin bad++; $display("FAIL b2b_count got=%0d exp=5", acks); end
        repeat (4) @(negedge clk);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", busy_o); end
    endtask

    initial begin
        test_reset;
        test_word;
        test_byte_lanes;
        test_half;
        test_faults;
        test_reset_midflight;
        test_back_to_back;
        for (int i = 0; i < 1; i++) begin
            if (lat < 0) begin bad++; $display("FAIL timeout got=%0d exp=%0d", lat, LAT); end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
